// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encodings, per-mode word and
// round counts, GF(2^8) doubling and the key-expansion FSM states.
package aes_pkg;

    localparam logic [1:0] KL_128 = 2'b00;
    localparam logic [1:0] KL_192 = 2'b01;
    localparam logic [1:0] KL_256 = 2'b10;
    localparam logic [1:0] KL_BAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GEN   = 2'b01,
        ST_DRAIN = 2'b10
    } ks_state_t;

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KL_128:  return 4'd4;
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_128:  return 4'd10;
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] c
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] acc;
        logic [7:0] xs;
        acc = 8'h00;
        xs  = x;
        for (int k = 0; k < 8; k++) begin
            acc = acc ^ (y[k] ? xs : 8'h00);
            xs  = xtime(xs);
        end
        return acc;
    endfunction

    // x^254 is the inverse for x != 0 and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] v);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // Combinational byte substitution
    always_comb begin
        c = affine(gf_inv(a));
    end

endmodule

// File: rtl/sub_word.sv
// 32-bit SubWord: four parallel S-box lookups, one per byte.
module sub_word (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sbox u_sbox (
            .a (i_word[8*g +: 8]),
            .c (o_word[8*g +: 8])
        );
    end

endmodule

// File: rtl/key_schedule_seq.sv
// Iterative AES-128/192/256 key expansion: one schedule word per clock into a
// word store, round keys streamed as they complete plus a random-access read.
module key_schedule_seq
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam int         DEPTH    = 4 * (MAX_NK + 7);
    localparam logic [3:0] MAX_NK_L = 4'(MAX_NK);
    localparam logic [6:0] DEPTH_L  = 7'(DEPTH);

    ks_state_t    r_state;
    ks_state_t    w_next_state;
    logic [31:0]  r_store [DEPTH];
    logic [31:0]  r_win [8];
    logic [5:0]   r_i;
    logic [5:0]   r_total;
    logic [2:0]   r_j;
    logic [7:0]   r_rcon;
    logic [3:0]   r_nk;
    logic [3:0]   r_nr;
    logic [3:0]   r_p;
    logic         r_rk_valid;
    logic         r_done;
    logic         r_err;
    logic [3:0]   r_rk_idx;
    logic [127:0] r_rk;

    logic [31:0]  w_key_word [8];
    logic [3:0]   w_nk_in;
    logic [3:0]   w_nr_in;
    logic         w_legal;
    logic         w_accept;
    logic         w_reject;
    logic         w_last_word;
    logic         w_emit;
    logic [31:0]  w_prev;
    logic [31:0]  w_sw_in;
    logic [31:0]  w_sw_out;
    logic [31:0]  w_temp;
    logic [31:0]  w_new;
    logic [2:0]   w_old_idx;
    logic [5:0]   w_rk_base;
    logic [6:0]   w_need;
    logic [5:0]   w_rd_base;

    // Split the MSB-aligned key into words w0..w7
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_key_word[k] = key_in[255-32*k -: 32];
        end
    end

    // Start qualification
    always_comb begin
        w_nk_in  = nk_of(key_len);
        w_nr_in  = nr_of(key_len);
        w_legal  = (key_len != KL_BAD) && (w_nk_in <= MAX_NK_L);
        w_accept = (r_state == ST_IDLE) && start && w_legal;
        w_reject = (r_state == ST_IDLE) && start && !w_legal;
    end

    // Next schedule word; r_win[0] is w[i-1], r_win[Nk-1] is w[i-Nk]
    always_comb begin
        w_prev    = r_win[0];
        w_old_idx = 3'(r_nk - 4'd1);
        w_sw_in   = (r_j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        if (r_j == 3'd0) begin
            w_temp = w_sw_out ^ {r_rcon, 24'h000000};
        end else if ((r_nk == 4'd8) && (r_j == 3'd4)) begin
            w_temp = w_sw_out;
        end else begin
            w_temp = w_prev;
        end
        w_new       = r_win[w_old_idx] ^ w_temp;
        w_last_word = (r_i == (r_total - 6'd1));
    end

    sub_word u_sub_word (
        .i_word (w_sw_in),
        .o_word (w_sw_out)
    );

    // A round key is ready once its four words sit in the store
    always_comb begin
        w_need    = {1'b0, r_p, 2'b00} + 7'd4;
        w_rk_base = {r_p, 2'b00};
        w_emit    = ((r_state == ST_GEN) || (r_state == ST_DRAIN))
                    && (r_p <= r_nr) && ({1'b0, r_i} >= w_need);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next_state = ST_GEN;
                else          w_next_state = ST_IDLE;
            end
            ST_GEN: begin
                if (w_last_word) w_next_state = ST_DRAIN;
                else             w_next_state = ST_GEN;
            end
            ST_DRAIN: begin
                if (r_p > r_nr) w_next_state = ST_IDLE;
                else            w_next_state = ST_DRAIN;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (r_state != ST_IDLE);
    end

    // Word counter, phase counter, rcon and per-mode constants
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i     <= 6'd0;
            r_j     <= 3'd0;
            r_rcon  <= 8'h01;
            r_total <= 6'd0;
            r_nk    <= 4'd0;
            r_nr    <= 4'd0;
        end else if (w_accept) begin
            r_i     <= {2'b00, w_nk_in};
            r_j     <= 3'd0;
            r_rcon  <= 8'h01;
            r_total <= {w_nr_in, 2'b00} + 6'd4;
            r_nk    <= w_nk_in;
            r_nr    <= w_nr_in;
        end else if (r_state == ST_GEN) begin
            r_i <= r_i + 6'd1;
            r_j <= ({1'b0, r_j} == (r_nk - 4'd1)) ? 3'd0 : r_j + 3'd1;
            if (r_j == 3'd0) begin
                r_rcon <= xtime(r_rcon);
            end
        end
    end

    // Sliding window of the last Nk words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) r_win[k] <= 32'h0;
        end else if (w_accept) begin
            for (int k = 0; k < 8; k++) begin
                r_win[k] <= (4'(k) < w_nk_in) ? w_key_word[3'(w_nk_in - 4'd1 - 4'(k))] : 32'h0;
            end
        end else if (r_state == ST_GEN) begin
            r_win[0] <= w_new;
            for (int k = 1; k < 8; k++) r_win[k] <= r_win[k-1];
        end
    end

    // Schedule word store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) r_store[k] <= 32'h0;
        end else if (w_accept) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < w_nk_in) r_store[k] <= w_key_word[k];
            end
        end else if (r_state == ST_GEN) begin
            r_store[r_i] <= w_new;
        end
    end

    // Round-key stream emitter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p        <= 4'd0;
            r_rk       <= 128'h0;
            r_rk_idx   <= 4'd0;
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
            if (w_accept) begin
                r_p <= 4'd0;
            end else if (w_emit) begin
                r_rk       <= {r_store[w_rk_base], r_store[w_rk_base + 6'd1],
                               r_store[w_rk_base + 6'd2], r_store[w_rk_base + 6'd3]};
                r_rk_idx   <= r_p;
                r_rk_valid <= 1'b1;
                r_done     <= (r_p == r_nr);
                r_p        <= r_p + 4'd1;
            end
        end
    end

    // Rejected-start pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_reject;
        end
    end

    // Zero-latency random-access read
    always_comb begin
        w_rd_base = {rd_idx, 2'b00};
        if (({1'b0, rd_idx, 2'b00} + 7'd3) < DEPTH_L) begin
            rd_key = {r_store[w_rd_base], r_store[w_rd_base + 6'd1],
                      r_store[w_rd_base + 6'd2], r_store[w_rd_base + 6'd3]};
        end else begin
            rd_key = 128'h0;
        end
    end

    assign done     = r_done;
    assign err      = r_err;
    assign rk_valid = r_rk_valid;
    assign rk_idx   = r_rk_idx;
    assign rk       = r_rk;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Self-checking bench for key_schedule_seq: table of FIPS-197 keys, a reference
// key-expansion model feeding a round-key scoreboard, and corner sequences.
module tb_key_schedule_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         start6;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic [3:0]   rd_idx;
    logic         busy, done, err, rk_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk, rd_key;
    logic         busy6, done6, err6, rk_valid6;
    logic [3:0]   rk_idx6;
    logic [127:0] rk6, rd_key6;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]   kl;
        logic [255:0] key;
        logic [127:0] last_rk;
        int           done_edge;
        int           nr;
    } vec_t;

    vec_t           vecs [3];
    logic [0:255][7:0] sbox_t;
    logic [7:0]     rcon_t [10];
    logic [31:0]    mw [60];
    logic [131:0]   sb [$];

    key_schedule_seq #(.MAX_NK(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
        .busy(busy), .done(done), .err(err), .rk_valid(rk_valid), .rk_idx(rk_idx),
        .rk(rk), .rd_idx(rd_idx), .rd_key(rd_key)
    );

    key_schedule_seq #(.MAX_NK(6)) u_dut6 (
        .clk(clk), .rst(rst), .start(start6), .key_len(key_len), .key_in(key_in),
        .busy(busy6), .done(done6), .err(err6), .rk_valid(rk_valid6), .rk_idx(rk_idx6),
        .rk(rk6), .rd_idx(rd_idx), .rd_key(rd_key6)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] m_sub(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Reference expansion; pushes every expected round key onto the scoreboard
    task automatic model_expand(input logic [1:0] kl, input logic [255:0] key);
        int nk, nr, total;
        logic [31:0] t;
        nk    = (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
        nr    = nk + 6;
        total = 4 * (nr + 1);
        for (int k = 0; k < nk; k++) mw[k] = key[255-32*k -: 32];
        for (int i = nk; i < total; i++) begin
            t = mw[i-1];
            if (i % nk == 0) t = m_sub({t[23:0], t[31:24]}) ^ {rcon_t[i/nk-1], 24'h0};
            else if (nk == 8 && i % 8 == 4) t = m_sub(t);
            mw[i] = mw[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) sb.push_back({4'(r), mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
    endtask

    task automatic run_vec(input int v, input bit pulse);
        int edges, pulses;
        bit saw_err, got_done;
        logic [131:0] e_rk;
        model_expand(vecs[v].kl, vecs[v].key);
        key_len = vecs[v].kl;
        key_in  = vecs[v].key;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        edges = 0; pulses = 0; saw_err = 0; got_done = 0;
        while (!got_done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (pulse && edges == 5) begin
                start = 1'b1; key_len = 2'b11; key_in = ~vecs[v].key;
            end
            if (pulse && edges == 6) begin
                start = 1'b0; key_len = vecs[v].kl; key_in = vecs[v].key;
            end
            if (err) saw_err = 1;
            if (rk_valid) begin
                pulses++;
                if (pulses == 1) check("first_rk_edge", edges, 1);
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e_rk = sb.pop_front();
                    check("rk_idx", rk_idx, e_rk[131:128]);
                    check("rk", rk, e_rk[127:0]);
                end
            end
            if (done) got_done = 1;
        end
        check("done_seen", got_done, 1);
        check("done_edge", edges, vecs[v].done_edge);
        check("final_rk_const", rk, vecs[v].last_rk);
        check("pulse_count", pulses, vecs[v].nr + 1);
        check("no_err_during_run", saw_err, 0);
        check("sb_drained", sb.size(), 0);
        @(posedge clk); #1;
        check("busy_cleared", busy, 0);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int nz;
        sbox_t = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        rcon_t = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        vecs[0] = '{2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef0123456789abcdeffeedface},
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 41, 10};
        vecs[1] = '{2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffffffffffff},
                    128'he98ba06f448c773c8ecc720401002202, 47, 12};
        vecs[2] = '{2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    128'hfe4890d1e6188d0b046df344706c631e, 53, 14};

        rst = 1'b1; start = 1'b0; start6 = 1'b0; key_len = 2'b00; key_in = '0; rd_idx = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, err, rk_valid, rk_idx, rk}, 0);
        check("reset_rd_key", rd_key, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back runs; the AES-192 run also gets a start pulsed while busy
        for (int v = 0; v < 3; v++) run_vec(v, v == 1);

        for (int r = 0; r < 15; r++) begin
            rd_idx = 4'(r); #1;
            check("rd_key_vs_model", rd_key, {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
        end
        rd_idx = 4'd15; #1;
        check("rd_key_beyond_depth", rd_key, 0);
        rd_idx = 4'd0;

        // Illegal key length is rejected and leaves the store alone
        @(posedge clk); #1;
        key_len = 2'b11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_illegal", err, 1);
        check("busy_after_reject", busy, 0);
        check("store_kept", rd_key, {mw[0], mw[1], mw[2], mw[3]});
        @(posedge clk); #1;
        check("err_one_cycle", err, 0);

        // AES-256 exceeds MAX_NK=6
        key_len = 2'b10; start6 = 1'b1;
        @(posedge clk); #1;
        start6 = 1'b0;
        check("err_nk_too_big", err6, 1);
        check("busy6_after_reject", busy6, 0);
        check("dut6_quiet", {done6, rk_valid6, rk_idx6, rk6, rd_key6}, 0);
        @(posedge clk); #1;
        check("err6_one_cycle", err6, 0);

        // Reset in the middle of an AES-256 expansion
        model_expand(vecs[2].kl, vecs[2].key);
        key_len = vecs[2].kl; key_in = vecs[2].key; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrun_reset_outputs", {busy, done, err, rk_valid, rk_idx, rk}, 0);
        nz = 0;
        for (int r = 0; r < 16; r++) begin
            rd_idx = 4'(r); #1;
            if (rd_key != 128'h0) nz++;
        end
        check("midrun_reset_store_clear", nz, 0);
        sb.delete();
        rd_idx = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_vec(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
